// File: rtl/mux_logical_if.sv
// rtl/mux_logical_if.sv - select/data input and registered status bundle for mux_logical
interface mux_logical_if;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       S;
  logic       R;
  logic [2:0] O;

  // Driver side: supplies data and select, observes the registered status
  modport master (
    output A, B, C, D, S, R,
    input  O
  );

  // Block side: consumes data and select, produces the registered status
  modport slave (
    input  A, B, C, D, S, R,
    output O
  );
endinterface

// File: rtl/mux_logical.sv
// rtl/mux_logical.sv - registered 4:1 mux plus 4-input logic unit with change flag (optional input stage: MUX_LOGICAL_INREG_EN)
module mux_logical #(
  parameter logic [2:0] RESET_VALUE = 3'b000
) (
  input logic          clk,
  input logic          rst,
  mux_logical_if.slave bus
);

  // Packed view of the inputs in the order {A,B,C,D,S,R}
  logic [5:0] in_raw;
  logic [5:0] in_use;

  assign in_raw = {bus.A, bus.B, bus.C, bus.D, bus.S, bus.R};

`ifdef MUX_LOGICAL_INREG_EN
  logic [5:0] in_q;

  // Input capture stage; adds one cycle of latency ahead of the result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q <= 6'b000000;
    end else begin
      in_q <= in_raw;
    end
  end

  assign in_use = in_q;
`else
  assign in_use = in_raw;
`endif

  logic       a_w, b_w, c_w, d_w;
  logic [1:0] sel_w;
  logic       parity_w;
  logic       mux_d;
  logic       fn_d;
  logic       chg_d;
  logic [2:0] o_d;
  logic [2:0] o_q;

  assign a_w      = in_use[5];
  assign b_w      = in_use[4];
  assign c_w      = in_use[3];
  assign d_w      = in_use[2];
  assign sel_w    = in_use[1:0];
  assign parity_w = a_w ^ b_w ^ c_w ^ d_w;

  // Next result: routed data bit, selected logic function, and change against current O[1:0]
  always_comb begin
    mux_d = 1'b0;
    fn_d  = 1'b0;
    unique case (sel_w)
      2'b00: begin
        mux_d = a_w;
        fn_d  = a_w & b_w & c_w & d_w;
      end
      2'b01: begin
        mux_d = b_w;
        fn_d  = a_w | b_w | c_w | d_w;
      end
      2'b10: begin
        mux_d = c_w;
        fn_d  = parity_w;
      end
      default: begin
        mux_d = d_w;
        fn_d  = ~parity_w;
      end
    endcase
    chg_d = ({fn_d, mux_d} != o_q[1:0]);
    o_d   = {chg_d, fn_d, mux_d};
  end

  // Result register; reset reloads RESET_VALUE, which also seeds the change comparison
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= RESET_VALUE;
    end else begin
      o_q <= o_d;
    end
  end

  assign bus.O = o_q;

endmodule

// File: tb/tb_mux_logical.sv
// tb/tb_mux_logical.sv - randomized and directed self-checking bench for mux_logical
module tb_mux_logical;
  localparam logic [2:0] RV = 3'b000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mux_logical_if bus ();

  mux_logical #(.RESET_VALUE(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: the routed bit is the indexed data input; the logic bit depends only on
  // how many of A..D are set and which operation the select names.
  function automatic logic [1:0] ref_fn(input logic [5:0] v);
    logic       d [4];
    int         ones;
    int         sel;
    logic       fn;
    d[0] = v[5];
    d[1] = v[4];
    d[2] = v[3];
    d[3] = v[2];
    sel  = int'(v[1:0]);
    ones = 0;
    for (int k = 0; k < 4; k++) ones += int'(d[k]);
    case (sel)
      0:       fn = (ones == 4);
      1:       fn = (ones > 0);
      2:       fn = (ones % 2 == 1);
      default: fn = (ones % 2 == 0);
    endcase
    return {fn, d[sel]};
  endfunction

  logic [2:0] exp_o   = RV;
  logic [5:0] stage_m = 6'b000000;

  // Behavioural model of the registered status
  always @(posedge clk or posedge rst) begin
    logic [5:0] src;
    logic [1:0] nv;
    if (rst) begin
      exp_o   = RV;
      stage_m = 6'b000000;
    end else begin
`ifdef MUX_LOGICAL_INREG_EN
      src = stage_m;
`else
      src = {bus.A, bus.B, bus.C, bus.D, bus.S, bus.R};
`endif
      nv      = ref_fn(src);
      exp_o   = {(nv != exp_o[1:0]), nv};
      stage_m = {bus.A, bus.B, bus.C, bus.D, bus.S, bus.R};
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    checks++;
    if (bus.O !== exp_o) begin
      errors++;
      $display("FAIL model_cmp t=%0t actual=%b required=%b", $time, bus.O, exp_o);
    end
  end

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic apply(input logic [5:0] v);
    {bus.A, bus.B, bus.C, bus.D, bus.S, bus.R} = v;
    @(negedge clk);
  endtask

  initial begin
    {bus.A, bus.B, bus.C, bus.D, bus.S, bus.R} = 6'b111111;
    #1 rst = 1'b1;
    #1 chk("reset_immediate", bus.O, 3'b000);
    @(negedge clk);
    @(negedge clk);
    chk("reset_held", bus.O, 3'b000);
    rst = 1'b0;

`ifndef MUX_LOGICAL_INREG_EN
    apply(6'b100000); chk("chg_first",  bus.O, 3'b101);
    apply(6'b100000); chk("chg_second", bus.O, 3'b001);
    apply(6'b100000); chk("chg_third",  bus.O, 3'b001);

    apply(6'b100000); chk("mux_sel00", {2'b00, bus.O[0]}, 3'b001);
    apply(6'b100001); chk("mux_sel01", {2'b00, bus.O[0]}, 3'b000);
    apply(6'b100010); chk("mux_sel10", {2'b00, bus.O[0]}, 3'b000);
    apply(6'b100011); chk("mux_sel11", {2'b00, bus.O[0]}, 3'b000);

    apply(6'b111000); chk("fn_and",  {2'b00, bus.O[1]}, 3'b000);
    apply(6'b111001); chk("fn_or",   {2'b00, bus.O[1]}, 3'b001);
    apply(6'b111010); chk("fn_xor",  {2'b00, bus.O[1]}, 3'b001);
    apply(6'b111011); chk("fn_xnor", {2'b00, bus.O[1]}, 3'b000);
`endif

    for (int i = 0; i < 64; i++) begin
      apply(6'(i));
      if (i == 32) begin
        #2 rst = 1'b1;
        #1 chk("reset_midsweep", bus.O, RV);
        @(negedge clk);
        chk("reset_midsweep_held", bus.O, RV);
        rst = 1'b0;
`ifndef MUX_LOGICAL_INREG_EN
        apply(6'b100000); chk("post_reset_chg", bus.O, 3'b101);
`endif
      end
    end

    for (int i = 0; i < 400; i++) begin
      apply(6'($urandom_range(0, 63)));
      if ($urandom_range(0, 39) == 0) begin
        #($urandom_range(1, 4)) rst = 1'b1;
        #1 chk("reset_random", bus.O, RV);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    repeat (3) apply({bus.A, bus.B, bus.C, bus.D, bus.S, bus.R});
    chk("stable_no_chg", {2'b00, bus.O[2]}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_logical.md
Name: mux_logical

Overview:
- Registered 4:1 data multiplexer combined with a selectable 4-input logic function unit.
- Two select bits {S,R} pick both the routed data bit and the logic operation applied across inputs A..D.
- A third output bit flags any change in the registered result.
- Used as a small control-path selector wherever a 3-bit registered status is needed.

Parameters:
- RESET_VALUE, 3'b000, value loaded into O on reset; bits [1:0] also seed the change-detect comparison.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- A  input  1  data input 0
- B  input  1  data input 1
- C  input  1  data input 2
- D  input  1  data input 3
- S  input  1  select MSB
- R  input  1  select LSB
- O  output  3  registered result: [0] mux bit, [1] logic-function bit, [2] change flag

Behaviour:
- sel = {S,R}. All inputs are sampled on the clk rising edge. No combinational path from inputs to O.
- mux_n (next O[0]):
  - sel 00 -> A
  - sel 01 -> B
  - sel 10 -> C
  - sel 11 -> D
- fn_n (next O[1]):
  - sel 00 -> A&B&C&D
  - sel 01 -> A|B|C|D
  - sel 10 -> A^B^C^D
  - sel 11 -> ~(A^B^C^D)
- chg_n (next O[2]): 1 when {fn_n,mux_n} differs from current O[1:0], else 0.
  - Pulses for exactly one cycle per change.
  - Stays 0 while inputs are held stable.
- Latency: 1 clk from input sample to O update. Throughput: one new result every cycle.
- Reset:
  - rst=1 forces O=RESET_VALUE immediately, independent of clk.
  - O holds while rst stays high.
  - First rising edge after rst deasserts computes from current inputs; change detect compares against RESET_VALUE[1:0].
- Reset asserted mid-operation discards the in-flight result; no partial update.
- Inputs changing between edges have no effect until the next edge. Unknown (X) inputs are not sanitised.
- All 64 input combinations are legal; no illegal-state handling is needed.

Optional Feature:
- Macro MUX_LOGICAL_INREG_EN.
- When defined:
  - A,B,C,D,S,R pass through an input register stage, also async-reset to 0.
  - Total latency becomes 2 clk.
  - Change detect still compares consecutive O[1:0] values.
- When undefined: single output register only, latency 1 clk.

Test Plan:
- Reset check: assert rst with inputs A=1,B=1,C=1,D=1,S=1,R=1 -> O=3'b000 immediately, held while rst=1.
- Mux routing: A=1,B=0,C=0,D=0; sweep sel 00,01,10,11 on successive edges -> O[0] = 1,0,0,0, each one clk after its sample.
- Logic function:
  - A=1,B=1,C=1,D=0 with sel 00 -> O[1]=0
  - sel 01 -> O[1]=1
  - sel 10 -> O[1]=1
  - sel 11 -> O[1]=0
- Change flag: hold A=1,B=0,C=0,D=0,S=0,R=0 for 3 edges after reset -> O = 3'b101, then 3'b001, then 3'b001.
- Exhaustive sweep: all 64 combinations of {A,B,C,D,S,R}, one per clk -> O[1:0] matches the reference model every cycle; O[2] matches the previous-vs-new comparison.
- Async reset mid-sweep: assert rst between edges -> O=3'b000 without a clk edge; after release, first O[2] compares against 2'b00.
